mux4x1_reg: RTL and testbench
=============================

// Module: mux4x1_reg
// PURPOSE
//   Parameterised 4:1 word multiplexer for datapath operand/result selection.
//   - out: purely combinational selection of one of four inputs by a 2-bit select.
//   - out_q: the same selection captured into a register on clk, gated by en.
//   - Used where a MIPS pipeline stage needs both a same-cycle and a pipelined mux result.
// PARAMETERS
//   WIDE  32  data width in bits of every data input and output (>=1)
// PORTS
//   Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
//   clk    in   1     rising-edge clock for out_q
//   rst_n  in   1     asynchronous active-low reset
//   in_00  in   WIDE  data selected when slct=2'b00
//   in_01  in   WIDE  data selected when slct=2'b01
//   in_10  in   WIDE  data selected when slct=2'b10
//   in_11  in   WIDE  data selected when slct=2'b11
//   slct   in   2     select
//   en     in   1     register load enable for out_q
//   out    out  WIDE  combinational mux result
//   out_q  out  WIDE  registered mux result
// BEHAVIOUR
//   - Combinational path: out = in_00/in_01/in_10/in_11 for slct = 0/1/2/3.
//     - Zero latency; out updates in the same delta as any input or slct change.
//     - Independent of clk, en and rst_n, including while reset is asserted.
//   - X/Z on slct drives out to all-X in simulation; no silent default to in_00.
//   - Registered path:
//     - rst_n low: out_q = {WIDE{1'b0}} immediately, without waiting for clk.
//     - While rst_n is low, out_q holds zero regardless of clk and en.
//     - Rising clk, rst_n high, en=1: out_q <= value of out at that edge.
//       Latency is 1 cycle from slct/data to out_q.
//     - Rising clk, rst_n high, en=0: out_q holds its previous value.
//   - Reset deassertion is taken synchronously to clk. The first load occurs at
//     the first rising edge after rst_n goes high with en=1.
//   - Reset asserted between edges clears out_q at once. Held data is lost; there
//     is no recovery of the pre-reset value.
//   - No truncation or extension: all data ports are exactly WIDE bits.
//     The selected word is passed bit-for-bit.
//   - slct changing on the same edge as capture: the value sampled is the
//     pre-edge slct (standard setup semantics).
// TESTING
//   1. WIDE=4, in_00=2,in_01=4,in_10=6,in_11=8; slct stepped 0,1,2,3 with no clock.
//      Expect out = 0010, 0100, 0110, 1000.
//   2. rst_n=0 with out_q previously 4'hF.
//      Expect out_q=0000 before any clk edge; out still follows slct.
//   3. rst_n=1, en=1, slct=2, clock one edge.
//      Expect out_q=0110 after the edge, and 0000 before it.
//   4. en=0, change slct to 3 and clock 3 edges.
//      Expect out_q stays 0110 while out=1000.
//   5. Assert rst_n low mid-cycle after loading 1000.
//      Expect out_q=0000 immediately; rst_n high with en=1 reloads on the next edge.
//   6. WIDE=32, random inputs/slct over 1000 cycles with random en.
//      Expect out to match the reference mux every cycle, and out_q to match the
//      previous-cycle out when en=1, else hold.

Source files
------------

// File: rtl/mux4x1_reg.sv
// 4:1 word mux with a same-cycle result and a registered copy.
// The register clears asynchronously and loads only when en is high.
module mux4x1_reg #(
  parameter int WIDE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WIDE-1:0] in_00,
  input  logic [WIDE-1:0] in_01,
  input  logic [WIDE-1:0] in_10,
  input  logic [WIDE-1:0] in_11,
  input  logic [1:0]      slct,
  input  logic            en,
  output logic [WIDE-1:0] out,
  output logic [WIDE-1:0] out_q
);

  logic [WIDE-1:0] w_sel;
  logic [WIDE-1:0] r_q;

  // Select one word; an unknown select propagates X instead of in_00.
  always_comb begin
    w_sel = {WIDE{1'bx}};
    case (slct)
      2'b00:   w_sel = in_00;
      2'b01:   w_sel = in_01;
      2'b10:   w_sel = in_10;
      2'b11:   w_sel = in_11;
      default: w_sel = {WIDE{1'bx}};
    endcase
  end

  // Capture the selected word when enabled; reset clears at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_sel;
    end
  end

  assign out   = w_sel;
  assign out_q = r_q;

endmodule

// File: tb/tb_mux4x1_reg.sv
// Bench for mux4x1_reg: directed WIDE=4 steps, then random WIDE=32
// traffic checked against an array-indexed reference with a held word.
module tb_mux4x1_reg;

  logic        clk;
  logic        rst_n;

  logic [3:0]  a [4];
  logic [1:0]  s4;
  logic        en4;
  logic [3:0]  out4;
  logic [3:0]  q4;

  logic [31:0] d [4];
  logic [1:0]  s32;
  logic        en32;
  logic [31:0] out32;
  logic [31:0] q32;

  int          n_pass;
  int          n_total;
  logic [31:0] mq;

  mux4x1_reg #(.WIDE(4)) u_w4 (
    .clk   (clk),
    .rst_n (rst_n),
    .in_00 (a[0]),
    .in_01 (a[1]),
    .in_10 (a[2]),
    .in_11 (a[3]),
    .slct  (s4),
    .en    (en4),
    .out   (out4),
    .out_q (q4)
  );

  mux4x1_reg #(.WIDE(32)) u_w32 (
    .clk   (clk),
    .rst_n (rst_n),
    .in_00 (d[0]),
    .in_01 (d[1]),
    .in_10 (d[2]),
    .in_11 (d[3]),
    .slct  (s32),
    .en    (en32),
    .out   (out32),
    .out_q (q32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    en4     = 1'b0;
    en32    = 1'b0;
    s4      = 2'd0;
    s32     = 2'd0;
    a[0] = 4'd2; a[1] = 4'd4; a[2] = 4'd6; a[3] = 4'd8;
    for (int i = 0; i < 4; i++) d[i] = '0;

    #2;
    chk("reset_q4", {28'd0, q4}, 32'd0);
    chk("reset_q32", q32, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Combinational selection, no edge in between
    for (int k = 0; k < 4; k++) begin
      s4 = 2'(k);
      #1;
      chk("comb_sel", {28'd0, out4}, 32'(2 * (k + 1)));
    end

    // Preload 4'hF into out_q
    @(negedge clk);
    a[0] = 4'hF;
    s4   = 2'd0;
    en4  = 1'b1;
    @(posedge clk); #1;
    chk("preload_F", {28'd0, q4}, 32'hF);
    a[0] = 4'd2;

    // Reset mid-cycle clears without an edge; out keeps following slct
    @(negedge clk);
    en4 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_clr", {28'd0, q4}, 32'd0);
    s4 = 2'd3;
    #1;
    chk("rst_out_live", {28'd0, out4}, 32'd8);
    en4 = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_edge", {28'd0, q4}, 32'd0);

    // Release, load slct=2 on one edge
    @(negedge clk);
    rst_n = 1'b1;
    s4    = 2'd2;
    en4   = 1'b1;
    #1;
    chk("pre_load_zero", {28'd0, q4}, 32'd0);
    @(posedge clk); #1;
    chk("load_6", {28'd0, q4}, 32'd6);

    // en low: hold across three edges while out moves
    @(negedge clk);
    en4 = 1'b0;
    s4  = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_q", {28'd0, q4}, 32'd6);
      chk("hold_out", {28'd0, out4}, 32'd8);
    end

    // Load 8, reset mid-cycle, reload on next edge
    @(negedge clk);
    en4 = 1'b1;
    @(posedge clk); #1;
    chk("load_8", {28'd0, q4}, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_clr", {28'd0, q4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("no_recover", {28'd0, q4}, 32'd0);
    @(posedge clk); #1;
    chk("reload_8", {28'd0, q4}, 32'd8);

    // Random WIDE=32 traffic against a reference model
    en4 = 1'b0;
    mq  = 32'd0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rnd_rst", q32, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      s32  = 2'($urandom_range(0, 3));
      en32 = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_out", out32, d[s32]);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        mq    = 32'd0;
        #1;
        chk("rnd_async", q32, 32'd0);
        rst_n = 1'b1;
      end
      if (en32) mq = d[s32];
      @(posedge clk); #1;
      chk("rnd_q", q32, mq);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
